// File: rtl/ejtag_pracc.sv
// EJTAG processor-access (PrAcc) bridge: parks a CPU debug-segment access until the
// probe completes it via a toggle from the TCK domain, or a timeout forces completion.
module ejtag_pracc #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1024,
    parameter logic [31:0] TO_RDATA    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        dm_err,
    input  logic        jtag_done_tgl,
    input  logic [31:0] jtag_data_in,
    output logic        pracc,
    output logic        prnw,
    output logic [31:0] addr_out,
    output logic [31:0] data_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_ACK
    } state_e;

    localparam logic [2:0]  WARM_DONE = 3'(SYNC_STAGES + 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
    localparam bit          TO_EN     = (TIMEOUT != 0);

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [2:0]             warm_q;
    logic [15:0]            cnt_q;
    logic                   pracc_q, prnw_q, ack_q, err_q;
    logic [31:0]            rdata_q, addr_q, wdata_q;
    logic                   edge_det;

    // Edges are ignored until the sync chain and history flop have both been
    // refilled after reset, so a high toggle level at release is not an edge.
    assign edge_det = (warm_q == WARM_DONE) && (sync_q[SYNC_STAGES-1] != hist_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sync_q  <= '0;
            hist_q  <= 1'b0;
            warm_q  <= '0;
            cnt_q   <= '0;
            pracc_q <= 1'b0;
            prnw_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], jtag_done_tgl};
            hist_q <= sync_q[SYNC_STAGES-1];
            if (warm_q != WARM_DONE) warm_q <= warm_q + 3'd1;
            ack_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (dm_req) begin
                        addr_q  <= dm_addr;
                        wdata_q <= dm_wdata;
                        prnw_q  <= dm_we;
                        pracc_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_PEND;
                    end
                end
                S_PEND: begin
                    cnt_q <= cnt_q + 16'd1;
                    // A probe edge wins over a simultaneous timeout.
                    if (edge_det) begin
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                        pracc_q <= 1'b0;
                        if (!prnw_q) rdata_q <= jtag_data_in;
                    end else if (TO_EN && cnt_q == TO_LAST) begin
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                        pracc_q <= 1'b0;
                        err_q   <= 1'b1;
                        if (!prnw_q) rdata_q <= TO_RDATA;
                    end
                end
                S_ACK: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dm_rdata = rdata_q;
    assign dm_ack   = ack_q;
    assign dm_err   = err_q;
    assign pracc    = pracc_q;
    assign prnw     = prnw_q;
    assign addr_out = addr_q;
    assign data_out = wdata_q;

endmodule

// File: tb/tb_ejtag_pracc.sv
// Directed bench for ejtag_pracc: read, write, timeout, spurious toggle, back-to-back
// and reset during a pending access.
module tb_ejtag_pracc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_ack, dm_err;
    logic        jtag_done_tgl;
    logic [31:0] jtag_data_in;
    logic        pracc, prnw;
    logic [31:0] addr_out, data_out;

    int n_cmp = 0;
    int n_err = 0;
    int ack_total = 0;

    always #5 clk = ~clk;

    ejtag_pracc #(
        .SYNC_STAGES(2),
        .TIMEOUT(16),
        .TO_RDATA(32'h0000_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
        .jtag_done_tgl(jtag_done_tgl), .jtag_data_in(jtag_data_in),
        .pracc(pracc), .prnw(prnw), .addr_out(addr_out), .data_out(data_out)
    );

    always @(posedge clk) if (dm_ack) ack_total <= ack_total + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one access from idle; lat = cycles from pracc rising to the ack (-1 if none).
    task automatic run_access(input string tag, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] din,
                              input logic toggle, output int lat, output logic [31:0] rd);
        dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        tick();
        check({tag, "_pracc"}, 32'(pracc), 32'd1);
        check({tag, "_prnw"}, 32'(prnw), 32'(we));
        check({tag, "_addr"}, addr_out, addr);
        check({tag, "_wdata"}, data_out, wdata);
        if (toggle) begin
            jtag_data_in  = din;
            jtag_done_tgl = ~jtag_done_tgl;
        end
        lat = -1;
        rd  = '0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (dm_ack && lat < 0) begin
                lat = i;
                rd  = dm_rdata;
                check({tag, "_pracc_at_ack"}, 32'(pracc), 32'd0);
                dm_req = 1'b0;
            end
        end
        dm_req = 1'b0;
    endtask

    int          lat, acks0, found;
    logic [31:0] rd;

    initial begin
        rst_n = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        jtag_done_tgl = 1'b0; jtag_data_in = '0;
        repeat (3) tick();
        check("rst_pracc", 32'(pracc), 32'd0);
        check("rst_ack", 32'(dm_ack), 32'd0);
        check("rst_err", 32'(dm_err), 32'd0);
        check("rst_rdata", dm_rdata, 32'd0);
        check("rst_addr", addr_out, 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Read completed by the probe.
        acks0 = ack_total;
        run_access("rd", 1'b0, 32'hFF20_0200, 32'h0, 32'h3C08_DEAD, 1'b1, lat, rd);
        check("rd_lat", 32'(lat), 32'd3);
        check("rd_data", rd, 32'h3C08_DEAD);
        check("rd_acks", 32'(ack_total - acks0), 32'd1);
        check("rd_err", 32'(dm_err), 32'd0);

        // Write leaves dm_rdata untouched.
        acks0 = ack_total;
        run_access("wr", 1'b1, 32'hFF20_1000, 32'h55AA_55AA, 32'h1234_5678, 1'b1, lat, rd);
        check("wr_lat", 32'(lat), 32'd3);
        check("wr_rdata_hold", rd, 32'h3C08_DEAD);
        check("wr_acks", 32'(ack_total - acks0), 32'd1);

        // Spurious toggle while idle, then a read that needs a fresh toggle.
        acks0 = ack_total;
        jtag_done_tgl = ~jtag_done_tgl;
        repeat (6) tick();
        check("spur_idle_acks", 32'(ack_total - acks0), 32'd0);
        check("spur_idle_pracc", 32'(pracc), 32'd0);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'hFF20_0300;
        tick();
        check("spur_pracc", 32'(pracc), 32'd1);
        repeat (8) tick();
        check("spur_no_ack", 32'(ack_total - acks0), 32'd0);
        check("spur_still_pend", 32'(pracc), 32'd1);
        jtag_data_in = 32'hCAFE_0001;
        jtag_done_tgl = ~jtag_done_tgl;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            tick();
            if (dm_ack) found = 1;
        end
        dm_req = 1'b0;
        check("spur_ack_seen", 32'(found), 32'd1);
        check("spur_rdata", dm_rdata, 32'hCAFE_0001);
        repeat (4) tick();
        check("spur_acks", 32'(ack_total - acks0), 32'd1);

        // Back-to-back: request held across the ack with a new address.
        acks0 = ack_total;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'hFF20_0200;
        tick();
        jtag_data_in = 32'h1111_2222;
        jtag_done_tgl = ~jtag_done_tgl;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            tick();
            if (dm_ack) found = 1;
        end
        check("b2b_ack1", 32'(found), 32'd1);
        check("b2b_rdata1", dm_rdata, 32'h1111_2222);
        dm_addr = 32'hFF20_0204;
        tick();
        check("b2b_idle_pracc", 32'(pracc), 32'd0);
        check("b2b_idle_ack", 32'(dm_ack), 32'd0);
        tick();
        check("b2b_pracc2", 32'(pracc), 32'd1);
        check("b2b_addr2", addr_out, 32'hFF20_0204);
        jtag_data_in = 32'h3333_4444;
        jtag_done_tgl = ~jtag_done_tgl;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            tick();
            if (dm_ack) found = 1;
        end
        dm_req = 1'b0;
        check("b2b_ack2", 32'(found), 32'd1);
        check("b2b_rdata2", dm_rdata, 32'h3333_4444);
        repeat (3) tick();
        check("b2b_acks", 32'(ack_total - acks0), 32'd2);

        // Timeout with no probe response.
        acks0 = ack_total;
        run_access("to", 1'b0, 32'hFF20_0400, 32'h0, 32'h0, 1'b0, lat, rd);
        check("to_lat", 32'(lat), 32'd16);
        check("to_rdata", rd, 32'h0000_0000);
        check("to_err", 32'(dm_err), 32'd1);
        check("to_acks", 32'(ack_total - acks0), 32'd1);

        // Error stays sticky across a later good access.
        run_access("post", 1'b0, 32'hFF20_0208, 32'h0, 32'hABCD_0123, 1'b1, lat, rd);
        check("post_lat", 32'(lat), 32'd3);
        check("post_rdata", rd, 32'hABCD_0123);
        check("post_err", 32'(dm_err), 32'd1);

        // Reset mid-PEND with the toggle input high at release.
        acks0 = ack_total;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'hFF20_0500;
        tick();
        check("mid_pracc", 32'(pracc), 32'd1);
        jtag_done_tgl = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pracc", 32'(pracc), 32'd0);
        check("mid_rst_ack", 32'(dm_ack), 32'd0);
        check("mid_rst_err", 32'(dm_err), 32'd0);
        dm_req = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("mid_no_ack", 32'(ack_total - acks0), 32'd0);
        check("mid_idle_pracc", 32'(pracc), 32'd0);

        // Block still functional after the reset.
        jtag_data_in = 32'h0BAD_F00D;
        run_access("after", 1'b0, 32'hFF20_0600, 32'h0, 32'h0BAD_F00D, 1'b1, lat, rd);
        check("after_lat", 32'(lat), 32'd3);
        check("after_rdata", rd, 32'h0BAD_F00D);
        check("after_acks", 32'(ack_total - acks0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
